div_arbiter: RTL and testbench
==============================

# div_arbiter

Round-robin scheduler that shares one 16-bit sequential divider core (start/done handshake, done held high for several cycles after completion) among N_REQ requesters. It latches the winning requester's operands, sequences the divider's start pulse, captures quotient/remainder on done, and returns them with a one-hot acknowledge. Divide-by-zero is resolved without touching the divider, and a watchdog recovers from a hung core. Sits between the divider core and the control units that issue divisions.

## Interface
- N_REQ, 4, number of requesters (2..8)
- W, 16, operand/result width
- TIMEOUT, 64, max cycles in WAIT before a division is aborted (≥ 2)

- clk  in  1  clock, all logic on posedge
- rst  in  1  reset, synchronous, active-high
- req  in  N_REQ  request per requester; level, held until its ack
- a_bus  in  N_REQ*W  dividends, requester i at [i*W +: W]
- b_bus  in  N_REQ*W  divisors, same packing
- ack  out  N_REQ  one-hot, one-cycle pulse: result for requester i is on res_*
- res_q  out  W  quotient, held until next ack
- res_r  out  W  remainder, held until next ack
- res_err  out  1  1 = divide-by-zero or timeout for this ack
- busy  out  1  high in every state except IDLE
- div_start  out  1  start pulse to divider
- div_a  out  W  dividend to divider (registered)
- div_b  out  W  divisor to divider (registered)
- div_done  in  1  divider done (level)
- div_q  in  W  divider quotient
- div_r  in  W  divider remainder

## Operation
- States: IDLE, ISSUE, WAIT, CAPTURE, ZERO, DRAIN. All outputs registered (Moore).
- IDLE: if any req, pick first set bit scanning from last_grant+1 modulo N_REQ; store index in gnt, latch that requester's a/b into op_a/op_b, set last_grant = gnt. If divisor == 0 → ZERO, else → ISSUE. No req → stay.
- ISSUE: div_start = 1 for exactly this cycle; div_a/div_b = op_a/op_b (held stable through WAIT); watchdog cleared → WAIT.
- WAIT: watchdog increments each cycle. div_done = 1 → sample div_q/div_r into res_q/res_r, res_err = 0 → CAPTURE. Watchdog reaches TIMEOUT with div_done = 0 → res_q = res_r = 0, res_err = 1 → CAPTURE.
- CAPTURE: ack[gnt] = 1 for one cycle → DRAIN.
- ZERO: res_q = all ones, res_r = op_a, res_err = 1, ack[gnt] = 1 for one cycle, no div_start → IDLE.
- DRAIN: wait until div_done = 0 (the core ignores start while done is high), then → IDLE. If div_done is already 0, leave after one cycle.
- Requesters hold req and operands stable until ack. Operands are sampled only at grant; changes afterwards are ignored. req still high in the cycle after ack is treated as a new request and arbitrated normally (round-robin: another pending requester wins first).
- Fairness: with all N_REQ requests permanently high, grants rotate 0,1,…,N_REQ-1,0,…
- Arithmetic is unsigned and delegated to the core. The block performs no width changes.

## Timing
- Reset values: ack = 0, res_q = 0, res_r = 0, res_err = 0, busy = 0, div_start = 0, div_a = 0, div_b = 0; state IDLE; last_grant = N_REQ-1, so requester 0 has first priority.
- Reset mid-operation (any state): returns to IDLE next cycle with no ack issued. The divider shares rst. The aborted requester keeps req high and is re-arbitrated.
- Req seen in IDLE at cycle T: div_start at T+1. Done first seen high at cycle D: ack and results at D+1.
- Zero divisor: req seen at T → ack at T+1. Back in IDLE at T+2.
- Timeout: ack with res_err = 1 at T+2+TIMEOUT.
- busy rises the cycle after the grant decision and falls on re-entry to IDLE.

## Test plan
- Single request: req[0] with a = 1000, b = 7; core model with done after 20 cycles → div_start exactly once; ack = 0001 with res_q = 142, res_r = 6, res_err = 0; busy low after done drops.
- Zero divisor: req[2] with a = 0x1234, b = 0 → ack = 0100 one cycle after the grant cycle; res_q = 0xFFFF, res_r = 0x1234, res_err = 1; div_start never asserted.
- Contention: req = 1111 held, each with distinct operands → ack order 0,1,2,3,0; each result matches its own operands; no div_start while div_done is high.
- Timeout: core model never raises done, TIMEOUT = 64 → ack at T+66 with res_q = res_r = 0, res_err = 1; the next request proceeds normally.
- Reset mid-WAIT: rst pulsed during WAIT → all outputs at reset values next cycle; no ack; with req still high, a fresh div_start follows.
- Operand change after grant: b_bus changes during WAIT → result reflects the operands latched at grant; div_b stable throughout.

Source files
------------

// File: rtl/div_arbiter.sv
// div_arbiter: round-robin scheduler sharing one sequential divider among N_REQ requesters
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   req, a_bus, b_bus        per-requester request level and packed operands
//   ack, res_q, res_r,       one-hot result strobe, quotient/remainder held until next ack,
//   res_err                  error flag (divide-by-zero or watchdog timeout)
//   busy                     high whenever not idle
//   div_start, div_a, div_b  start pulse and registered operands to the divider core
//   div_done, div_q, div_r   done level and results from the divider core
module div_arbiter #(
    parameter int N_REQ   = 4,
    parameter int W       = 16,
    parameter int TIMEOUT = 64
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_REQ-1:0]   req,
    input  logic [N_REQ*W-1:0] a_bus,
    input  logic [N_REQ*W-1:0] b_bus,
    output logic [N_REQ-1:0]   ack,
    output logic [W-1:0]       res_q,
    output logic [W-1:0]       res_r,
    output logic               res_err,
    output logic               busy,
    output logic               div_start,
    output logic [W-1:0]       div_a,
    output logic [W-1:0]       div_b,
    input  logic               div_done,
    input  logic [W-1:0]       div_q,
    input  logic [W-1:0]       div_r
);
    localparam int IW = $clog2(N_REQ);
    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, CAPTURE, ZERO, DRAIN} state_t;

    state_t state, nstate;
    // gnt doubles as last_grant: it only changes at a grant, so both are always equal
    logic [IW-1:0] gnt, pick, idx;
    logic any;
    logic [W-1:0] sel_a, sel_b;
    logic [CW-1:0] wd;
    logic wd_hit;
    logic [N_REQ-1:0] ack_n;
    logic [W-1:0] q_n, r_n;
    logic err_n, busy_n, start_n;

    // Descending scan so the lowest offset after gnt is the last (winning) assignment
    always_comb begin
        pick = gnt;
        any = 1'b0;
        idx = '0;
        for (int k = N_REQ; k >= 1; k--) begin
            idx = IW'((int'(gnt) + k) % N_REQ);
            if (req[idx]) begin
                pick = idx;
                any = 1'b1;
            end
        end
    end

    assign sel_a = a_bus[int'(pick)*W +: W];
    assign sel_b = b_bus[int'(pick)*W +: W];
    // WAIT is entered with wd = 0, so this fires on the TIMEOUT-th WAIT cycle
    assign wd_hit = wd == CW'(TIMEOUT - 1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            gnt <= IW'(N_REQ - 1);
            wd <= '0;
            ack <= '0;
            res_q <= '0;
            res_r <= '0;
            res_err <= 1'b0;
            busy <= 1'b0;
            div_start <= 1'b0;
            div_a <= '0;
            div_b <= '0;
        end else begin
            state <= nstate;
            wd <= (state == WAIT) ? wd + CW'(1) : '0;
            ack <= ack_n;
            res_q <= q_n;
            res_r <= r_n;
            res_err <= err_n;
            busy <= busy_n;
            div_start <= start_n;
            if (state == IDLE && any)
                gnt <= pick;
            // Operands latched at grant; the divider copy is only loaded for a real division
            if (nstate == ISSUE) begin
                div_a <= sel_a;
                div_b <= sel_b;
            end
        end
    end

    always_comb begin
        nstate = state;
        case (state)
            IDLE:    if (any) nstate = (sel_b == '0) ? ZERO : ISSUE;
            ISSUE:   nstate = WAIT;
            WAIT:    if (div_done || wd_hit) nstate = CAPTURE;
            CAPTURE: nstate = DRAIN;
            ZERO:    nstate = IDLE;
            DRAIN:   if (!div_done) nstate = IDLE;
            default: nstate = IDLE;
        endcase
    end

    // Next values of the registered outputs; done takes priority over a same-cycle timeout
    always_comb begin
        ack_n = '0;
        q_n = res_q;
        r_n = res_r;
        err_n = res_err;
        busy_n = nstate != IDLE;
        start_n = nstate == ISSUE;
        if (nstate == ZERO) begin
            ack_n[pick] = 1'b1;
            q_n = '1;
            r_n = sel_a;
            err_n = 1'b1;
        end
        if (state == WAIT && nstate == CAPTURE) begin
            ack_n[gnt] = 1'b1;
            q_n = div_done ? div_q : '0;
            r_n = div_done ? div_r : '0;
            err_n = !div_done;
        end
    end
endmodule

// File: tb/tb_div_arbiter.sv
// tb_div_arbiter: directed bench for div_arbiter with a behavioural divider core model
module tb_div_arbiter;
    localparam int N = 4;
    localparam int W = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [N-1:0] req = '0;
    logic [N*W-1:0] a_bus = '0;
    logic [N*W-1:0] b_bus = '0;
    logic [N-1:0] ack;
    logic [W-1:0] res_q, res_r, div_a, div_b;
    logic res_err, busy, div_start;
    logic div_done = 1'b0;
    logic [W-1:0] div_q = '0;
    logic [W-1:0] div_r = '0;

    int cyc = 0;
    int lat = 20;
    logic hang = 1'b0;
    int cnt = 0;
    int hold = 0;
    logic [W-1:0] ma = '0;
    logic [W-1:0] mb = '0;
    int starts = 0;
    int viol = 0;
    int n_cmp = 0;
    int n_err = 0;

    div_arbiter #(.N_REQ(N), .W(W), .TIMEOUT(64)) dut (
        .clk(clk), .rst(rst), .req(req), .a_bus(a_bus), .b_bus(b_bus),
        .ack(ack), .res_q(res_q), .res_r(res_r), .res_err(res_err), .busy(busy),
        .div_start(div_start), .div_a(div_a), .div_b(div_b),
        .div_done(div_done), .div_q(div_q), .div_r(div_r)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Divider core: done rises lat cycles after start, stays high 3 cycles, ignores start while done
    always @(posedge clk) begin
        if (div_start) starts <= starts + 1;
        if (div_start && div_done) viol <= viol + 1;
        if (rst) begin
            cnt <= 0;
            hold <= 0;
            div_done <= 1'b0;
        end else if (div_start && !div_done) begin
            ma <= div_a;
            mb <= div_b;
            cnt <= lat;
        end else if (cnt > 0) begin
            cnt <= cnt - 1;
            if (cnt == 1 && !hang) begin
                div_done <= 1'b1;
                div_q <= ma / mb;
                div_r <= ma % mb;
                hold <= 3;
            end
        end else if (hold > 0) begin
            hold <= hold - 1;
            if (hold == 1) div_done <= 1'b0;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_ack(input int limit, output int at);
        at = -1;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (ack != '0) begin
                at = cyc;
                break;
            end
        end
    endtask

    task automatic wait_idle(input string tag);
        for (int i = 0; i < 50 && busy; i++) @(negedge clk);
        check(tag, busy, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int t0, at;
        logic [3:0] exp_ack [5];
        logic [15:0] exp_q [5];
        logic [15:0] exp_r [5];
        // Reset values
        @(negedge clk);
        @(negedge clk);
        check("rst_ack", ack, 0);
        check("rst_res", {res_q, res_r, res_err}, 0);
        check("rst_ctl", {busy, div_start}, 0);
        check("rst_div_ab", {div_a, div_b}, 0);
        rst = 1'b0;
        // Single request: 1000 / 7 = 142 r 6, done after 20 cycles
        @(negedge clk);
        t0 = cyc;
        a_bus[0*W +: W] = 16'd1000;
        b_bus[0*W +: W] = 16'd7;
        req = 4'b0001;
        @(negedge clk);
        check("t1_start", div_start, 1);
        check("t1_div_a", div_a, 1000);
        check("t1_div_b", div_b, 7);
        check("t1_busy", busy, 1);
        wait_ack(100, at);
        check("t1_ack_time", at, t0 + 23);
        check("t1_ack", ack, 4'b0001);
        check("t1_q", res_q, 142);
        check("t1_r", res_r, 6);
        check("t1_err", res_err, 0);
        req = '0;
        @(negedge clk);
        check("t1_ack_pulse", ack, 0);
        check("t1_busy_drain", busy, 1);
        @(negedge clk);
        check("t1_busy_done_high", busy, 1);
        @(negedge clk);
        check("t1_busy_low", busy, 0);
        check("t1_starts", starts, 1);
        // Zero divisor on requester 2
        a_bus[2*W +: W] = 16'h1234;
        b_bus[2*W +: W] = 16'h0000;
        req = 4'b0100;
        @(negedge clk);
        check("t2_ack", ack, 4'b0100);
        check("t2_q", res_q, 16'hFFFF);
        check("t2_r", res_r, 16'h1234);
        check("t2_err", res_err, 1);
        check("t2_no_start", div_start, 0);
        req = '0;
        @(negedge clk);
        check("t2_ack_pulse", ack, 0);
        check("t2_idle", busy, 0);
        check("t2_starts", starts, 1);
        // Contention after reset: order 0,1,2,3,0
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        lat = 5;
        a_bus[0*W +: W] = 16'd100;   b_bus[0*W +: W] = 16'd9;
        a_bus[1*W +: W] = 16'd65535; b_bus[1*W +: W] = 16'd256;
        a_bus[2*W +: W] = 16'd5;     b_bus[2*W +: W] = 16'd10;
        a_bus[3*W +: W] = 16'hABCD;  b_bus[3*W +: W] = 16'd1;
        exp_ack[0] = 4'b0001; exp_q[0] = 16'd11;     exp_r[0] = 16'd1;
        exp_ack[1] = 4'b0010; exp_q[1] = 16'd255;    exp_r[1] = 16'd255;
        exp_ack[2] = 4'b0100; exp_q[2] = 16'd0;      exp_r[2] = 16'd5;
        exp_ack[3] = 4'b1000; exp_q[3] = 16'hABCD;   exp_r[3] = 16'd0;
        exp_ack[4] = 4'b0001; exp_q[4] = 16'd11;     exp_r[4] = 16'd1;
        req = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            wait_ack(60, at);
            check($sformatf("t3_ack%0d", i), ack, exp_ack[i]);
            check($sformatf("t3_res%0d", i), {res_q, res_r, res_err}, {exp_q[i], exp_r[i], 1'b0});
        end
        req = '0;
        wait_idle("t3_idle");
        check("t3_starts", starts, 6);
        check("t3_no_start_while_done", viol, 0);
        // Timeout: core never finishes
        hang = 1'b1;
        a_bus[1*W +: W] = 16'd50;
        b_bus[1*W +: W] = 16'd3;
        t0 = cyc;
        req = 4'b0010;
        wait_ack(200, at);
        check("t4_ack_time", at, t0 + 66);
        check("t4_ack", ack, 4'b0010);
        check("t4_res", {res_q, res_r, res_err}, {16'd0, 16'd0, 1'b1});
        req = '0;
        @(negedge clk);
        check("t4_busy_drain", busy, 1);
        @(negedge clk);
        check("t4_idle", busy, 0);
        hang = 1'b0;
        a_bus[2*W +: W] = 16'd77;
        b_bus[2*W +: W] = 16'd7;
        req = 4'b0100;
        wait_ack(60, at);
        check("t4_next_ack", ack, 4'b0100);
        check("t4_next_res", {res_q, res_r, res_err}, {16'd11, 16'd0, 1'b0});
        req = '0;
        wait_idle("t4_next_idle");
        // Reset in the middle of WAIT
        lat = 30;
        a_bus[3*W +: W] = 16'd200;
        b_bus[3*W +: W] = 16'd6;
        req = 4'b1000;
        for (int i = 0; i < 6; i++) @(negedge clk);
        check("t5_in_wait", {busy, div_start}, 2'b10);
        rst = 1'b1;
        @(negedge clk);
        check("t5_rst_ack", ack, 0);
        check("t5_rst_res", {res_q, res_r, res_err}, 0);
        check("t5_rst_ctl", {busy, div_start, div_a, div_b}, 0);
        rst = 1'b0;
        @(negedge clk);
        check("t5_restart", div_start, 1);
        check("t5_restart_a", div_a, 200);
        wait_ack(60, at);
        check("t5_ack", ack, 4'b1000);
        check("t5_res", {res_q, res_r, res_err}, {16'd33, 16'd2, 1'b0});
        req = '0;
        wait_idle("t5_idle");
        // Operand change after grant
        lat = 10;
        a_bus[1*W +: W] = 16'd1000;
        b_bus[1*W +: W] = 16'd10;
        req = 4'b0010;
        @(negedge clk);
        check("t6_start", div_start, 1);
        for (int i = 0; i < 3; i++) @(negedge clk);
        a_bus[1*W +: W] = 16'd999;
        b_bus[1*W +: W] = 16'd3;
        @(negedge clk);
        @(negedge clk);
        check("t6_div_ab_stable", {div_a, div_b}, {16'd1000, 16'd10});
        wait_ack(60, at);
        check("t6_ack", ack, 4'b0010);
        check("t6_res", {res_q, res_r, res_err}, {16'd100, 16'd0, 1'b0});
        check("t6_div_b_end", div_b, 10);
        req = '0;
        wait_idle("t6_idle");
        check("final_no_start_while_done", viol, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
